rs_encoder: RTL and testbench
=============================

# rs_encoder

Systematic Reed-Solomon RS(7,3) encoder over GF(8). It accepts a 9-bit message of three 3-bit symbols and produces a 21-bit codeword of seven symbols that carries four parity symbols, correcting up to 2 symbol errors. It sits on the transmit side, upstream of the channel, and is the producer for RS_Decoder. Parity is computed serially by a 4-stage LFSR divider, one message symbol per clock.

## Interface
- Parameters: none. The field, code and generator polynomial are fixed.
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- in_valid  in  1  message present on `message`
- in_ready  out  1  encoder can accept a message
- message  in  9  message symbols; `message[3j+2:3j]` = m_j (j=0..2)
- out_valid  out  1  `codeword` is valid
- out_ready  in  1  consumer accepts the codeword
- codeword  out  21  `codeword[3i+2:3i]` = c_i, the coefficient of x^i (i=0..6)

## Operation
- **Symbol format:** polynomial basis, primitive polynomial p(x)=x^3+x+1, α=3'b010. Bit k is the coefficient of α^k.
  - Powers: α^0=1, α^1=2, α^2=4, α^3=3, α^4=6, α^5=7, α^6=5.
- **Field arithmetic:** addition is bitwise XOR. Multiplication by constants uses fixed XOR networks, with no log tables.
- **Generator polynomial:** g(x)=(x+α)(x+α^2)(x+α^3)(x+α^4) = x^4 + 3x^3 + 1x^2 + 2x + 3. So g3=3, g2=1, g1=2, g0=3.
- **Codeword construction:** c(x) = m(x)·x^4 + (m(x)·x^4 mod g(x)).
  - c6..c4 = m2..m0.
  - c3..c0 = parity r3..r0.
- **LFSR step:** one step per message symbol, taken in order m2, then m1, then m0.
  - fb = m + r3
  - r3' = r2 + fb·3
  - r2' = r1 + fb·1
  - r1' = r0 + fb·2
  - r0' = fb·3
- **States:**
  - IDLE: in_ready=1, out_valid=0. On in_valid, latch `message`, clear r3..r0, clear the symbol counter, and go to CALC.
  - CALC: in_ready=0. Perform one LFSR step per cycle using the latched symbol selected by the counter (2, then 1, then 0). After the third step, go to DONE.
  - DONE: out_valid=1. `codeword` = {m2,m1,m0,r3,r2,r1,r0}. On out_ready, go to IDLE.
- **Handshake rules:**
  - in_ready is a decode of state and has no combinational path from in_valid or out_ready.
  - A message transfers when in_valid && in_ready at a rising edge.
  - A codeword transfers when out_valid && out_ready at a rising edge.
- **Stability:** `codeword` and out_valid stay stable while out_valid=1 and out_ready=0, for any number of stall cycles.
- **Ignored inputs:** in_valid is ignored outside IDLE. `message` changes after the accept edge have no effect.
- **Don't-care inputs:** out_ready is a don't-care outside DONE.

## Timing
- **Reset:** reset at edge E puts the block in IDLE after E.
  - Outputs after reset: in_ready=1, out_valid=0, codeword=21'h0.
  - Parity registers, latched message and counter are cleared.
- **Reset mid-operation:** reset in CALC or DONE aborts the current message with no output. The pending codeword is discarded. Reset takes priority over every handshake at the same edge.
- **Latency:** a message accepted at edge N gives out_valid=1 after edge N+3. The CALC steps occur at edges N+1, N+2 and N+3.
- **Throughput:**
  - With out_ready held high, a codeword transfers at edge N+4. in_ready returns to 1 after N+4, so the next message is accepted at N+5 at the earliest.
  - Peak throughput is 1 codeword per 5 cycles.
- **No overlap:** there is no simultaneous accept and emit. in_ready=0 in DONE, so an in_valid arriving during a stall waits.
- **Counter:** 2-bit, values 0..2 in CALC only, no wrap-around beyond 2.
- **All-zero message:** produces an all-zero codeword through the same 3-step path, with no short-cut.

## Test plan
- Reset, then message 9'h000 → 4 cycles later codeword=21'h000000 with out_valid=1, latency exactly 3 edges after accept.
- message 9'h001 (m0=1) → codeword 21'h001653 (c(x)=g(x)).
- message 9'h040 (m2=1) → codeword 21'h040C77.
- message 9'h041 → codeword 21'h041A24 (linearity check: XOR of the previous two).
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and message → codeword and out_valid stay constant, in_ready=0, no second accept. Release out_ready → one transfer, then in_ready=1.
- Assert reset for 1 cycle at the second CALC cycle → in_ready=1, out_valid=0, codeword=0 the next cycle. A following message 9'h001 produces 21'h001653 with normal latency.
- Self-check every codeword: evaluating c(x) at α, α^2, α^3 and α^4 gives 0 for every random message across a 1000-message run.

Source files
------------

// File: rtl/rs_encoder.sv
// rtl/rs_encoder.sv - Systematic RS(7,3) encoder over GF(8) with a serial LFSR parity divider
//
// Purpose: accepts a 9-bit message of three 3-bit symbols and produces a
// 21-bit codeword. The codeword holds the three message symbols followed by
// four parity symbols. Parity is computed one message symbol per clock,
// taking m2, then m1, then m0.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   message present on message
//   in_ready   out  1   encoder can accept a message (decode of state only)
//   message    in   9   message[3j+2:3j] = m_j
//   out_valid  out  1   codeword is valid
//   out_ready  in   1   consumer accepts the codeword
//   codeword   out  21  codeword[3i+2:3i] = c_i, the coefficient of x^i

module rs_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  message,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [20:0] codeword
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [8:0]  msg_q;
    logic [2:0]  r0_q;
    logic [2:0]  r1_q;
    logic [2:0]  r2_q;
    logic [2:0]  r3_q;
    logic [1:0]  cnt_q;

    logic [2:0]  sym;
    logic [2:0]  fb;
    logic [2:0]  fb_x2;
    logic [2:0]  fb_x3;

    // Multiply by alpha in GF(8) with p(x) = x^3 + x + 1:
    // the bit shifted out of x^2 folds back as x + 1.
    function automatic logic [2:0] gf_mul2(input logic [2:0] a);
        return {a[1], a[2] ^ a[0], a[2]};
    endfunction

    // Counter 0, 1, 2 selects m2, m1, m0 so the highest-order symbol enters first.
    always_comb begin
        sym = msg_q[2:0];
        case (cnt_q)
            2'd0:    sym = msg_q[8:6];
            2'd1:    sym = msg_q[5:3];
            default: sym = msg_q[2:0];
        endcase
    end

    assign fb    = sym ^ r3_q;
    assign fb_x2 = gf_mul2(fb);
    assign fb_x3 = fb_x2 ^ fb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == 2'd2) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Generator g(x) = x^4 + 3x^3 + 1x^2 + 2x + 3 sets the feedback taps.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_q <= 9'h000;
            r0_q  <= 3'd0;
            r1_q  <= 3'd0;
            r2_q  <= 3'd0;
            r3_q  <= 3'd0;
            cnt_q <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        msg_q <= message;
                        r0_q  <= 3'd0;
                        r1_q  <= 3'd0;
                        r2_q  <= 3'd0;
                        r3_q  <= 3'd0;
                        cnt_q <= 2'd0;
                    end
                end
                ST_CALC: begin
                    r3_q  <= r2_q ^ fb_x3;
                    r2_q  <= r1_q ^ fb;
                    r1_q  <= r0_q ^ fb_x2;
                    r0_q  <= fb_x3;
                    cnt_q <= (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign codeword = {msg_q, r3_q, r2_q, r1_q, r0_q};

endmodule

// File: tb/tb_rs_encoder.sv
// tb/tb_rs_encoder.sv - Self-checking bench for rs_encoder against a polynomial long-division model

module tb_rs_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  message;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] codeword;

    int errors;
    int checks;

    rs_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .message   (message),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeword  (codeword)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(8) multiply: shift-and-add with reduction by x^3 + x + 1.
    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] aa;
        logic [2:0] res;
        aa  = {1'b0, a};
        res = 3'd0;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) res = res ^ aa[2:0];
            aa = aa << 1;
            if (aa[3]) aa = aa ^ 4'b1011;
        end
        return res;
    endfunction

    // c(x) = m(x) x^4 + (m(x) x^4 mod g(x)), remainder by long division.
    function automatic logic [20:0] model_encode(input logic [8:0] m);
        logic [2:0] a [0:6];
        logic [2:0] g [0:4];
        logic [2:0] q;
        g[0] = 3'd3; g[1] = 3'd2; g[2] = 3'd1; g[3] = 3'd3; g[4] = 3'd1;
        for (int i = 0; i < 7; i++) a[i] = 3'd0;
        a[6] = m[8:6];
        a[5] = m[5:3];
        a[4] = m[2:0];
        for (int i = 6; i >= 4; i--) begin
            q = a[i];
            for (int k = 0; k <= 4; k++) a[i - 4 + k] = a[i - 4 + k] ^ gf_mul(q, g[k]);
        end
        return {m, a[3], a[2], a[1], a[0]};
    endfunction

    // Horner evaluation of the codeword polynomial at point x.
    function automatic logic [2:0] eval_at(input logic [20:0] cw, input logic [2:0] x);
        logic [2:0] acc;
        acc = 3'd0;
        for (int i = 6; i >= 0; i--) acc = gf_mul(acc, x) ^ cw[3 * i +: 3];
        return acc;
    endfunction

    function automatic logic [11:0] syndromes(input logic [20:0] cw);
        // alpha^1..alpha^4 = 2, 4, 3, 6
        return {eval_at(cw, 3'd2), eval_at(cw, 3'd4), eval_at(cw, 3'd3), eval_at(cw, 3'd6)};
    endfunction

    // Present a message until it is accepted; returns edges waited, or -1 on timeout.
    task automatic accept_msg(input logic [8:0] m, output int waited);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            waited = -1;
        end else begin
            in_valid = 1'b1;
            message  = m;
            @(posedge clk); #1;
            in_valid = 1'b0;
            message  = 9'($urandom);
        end
    endtask

    // Count edges after the accept edge until out_valid rises (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        message   = 9'h1FF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (codeword !== 21'h0) begin errors++; $display("FAIL reset_codeword got=%h want=000000", codeword); end
    endtask

    task automatic test_vectors();
        logic [8:0]  msgs [0:3];
        logic [20:0] exps [0:3];
        int w;
        int lat;
        msgs[0] = 9'h000; exps[0] = 21'h000000;
        msgs[1] = 9'h001; exps[1] = 21'h001653;
        msgs[2] = 9'h040; exps[2] = 21'h040C77;
        msgs[3] = 9'h041; exps[3] = 21'h041A24;
        for (int i = 0; i < 4; i++) begin
            accept_msg(msgs[i], w);
            checks++;
            if (w < 0) begin errors++; $display("FAIL vec_accept_timeout msg=%h", msgs[i]); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL vec_in_ready_calc got=%b want=0", in_ready); end
            wait_valid(lat);
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL vec_latency msg=%h got=%0d want=3", msgs[i], lat); end
            checks++;
            if (codeword !== exps[i]) begin errors++; $display("FAIL vec_codeword msg=%h got=%h want=%h", msgs[i], codeword, exps[i]); end
            release_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL vec_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_stall();
        logic [20:0] exp;
        int w;
        int lat;
        exp = model_encode(9'h123);
        accept_msg(9'h123, w);
        wait_valid(lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL stall_latency got=%0d want=3", lat); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            message  = 9'($urandom);
            @(posedge clk); #1;
            checks++;
            if (codeword !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d codeword=%h want=%h out_valid=%b in_ready=%b want 1/0",
                         i, codeword, exp, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_no_second_accept in_ready=%b want=1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int w;
        int lat;
        accept_msg(9'h0AB, w);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || codeword !== 21'h0) begin
            errors++;
            $display("FAIL reset_mid in_ready=%b out_valid=%b codeword=%h want 1/0/000000", in_ready, out_valid, codeword);
        end
        accept_msg(9'h001, w);
        wait_valid(lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL reset_mid_latency got=%0d want=3", lat); end
        checks++;
        if (codeword !== 21'h001653) begin errors++; $display("FAIL reset_mid_codeword got=%h want=001653", codeword); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [8:0]  m;
        logic [20:0] exp;
        int gap;
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m   = 9'($urandom);
            exp = model_encode(m);
            accept_msg(m, w);
            gap = 1;
            while (!in_ready && gap < 12) begin
                if (out_valid) begin
                    checks++;
                    if (gap !== 4 || codeword !== exp) begin
                        errors++; $display("FAIL b2b_emit at=%0d want=4 codeword=%h want=%h", gap, codeword, exp);
                    end
                end
                @(posedge clk); #1;
                gap++;
            end
            checks++;
            if (gap !== 5) begin errors++; $display("FAIL b2b_next_accept got=N+%0d want=N+5", gap); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [8:0]  m;
        logic [20:0] exp;
        int w;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            m   = 9'($urandom);
            exp = model_encode(m);
            accept_msg(m, w);
            wait_valid(lat);
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL rand_latency msg=%h got=%0d want=3", m, lat); end
            checks++;
            if (codeword !== exp) begin errors++; $display("FAIL rand_codeword msg=%h got=%h want=%h", m, codeword, exp); end
            checks++;
            if (syndromes(codeword) !== 12'h000) begin
                errors++; $display("FAIL rand_syndrome msg=%h codeword=%h got=%h want=000", m, codeword, syndromes(codeword));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            release_out();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_vectors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
